// File: rtl/execute_hazard_unit.sv
// execute_hazard_unit: ALU operand forwarding, load-use stall/bubble and memory-wait freeze for the execute stage.
// Latency: every output is combinational from the inputs and the MEM/WB shadow registers; the shadows advance one stage per edge.
// Backpressure: while the MEM-stage access is not ready, freeze_o holds every pipeline register and both shadow stages.
// Ports: clk_i/reset_i (synchronous, active-high); id_src*_{addr,valid}_i are the decode sources;
//   ex_*_i are the ID/EX register outputs; mem_ready_i is the data memory handshake;
//   fwd_sel_{1,2}_o (00 reg file, 01 MEM, 10 WB), stall_o, id_ex_flush_o, freeze_o.
// Optional HAZARD_STATS_EN adds load_use_count_o / mem_wait_count_o (saturating).
module execute_hazard_unit #(
  parameter int ADDR_WIDTH = 4,
  parameter int PC_ADDR    = 15,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [ADDR_WIDTH-1:0] id_src1_addr_i,
  input  logic                  id_src1_valid_i,
  input  logic [ADDR_WIDTH-1:0] id_src2_addr_i,
  input  logic                  id_src2_valid_i,
  input  logic [ADDR_WIDTH-1:0] ex_src1_addr_i,
  input  logic [ADDR_WIDTH-1:0] ex_src2_addr_i,
  input  logic [ADDR_WIDTH-1:0] ex_dest_addr_i,
  input  logic                  ex_reg_write_i,
  input  logic                  ex_mem_read_i,
  input  logic                  ex_mem_write_i,
  input  logic                  mem_ready_i,
  output logic [1:0]            fwd_sel_1_o,
  output logic [1:0]            fwd_sel_2_o,
  output logic                  stall_o,
  output logic                  id_ex_flush_o,
  output logic                  freeze_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] load_use_count_o,
  output logic [STAT_WIDTH-1:0] mem_wait_count_o
`endif
);

  localparam logic [ADDR_WIDTH-1:0] PC_REG = ADDR_WIDTH'(PC_ADDR);

  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t state;

  // Shadow copies of the destination/write info for the MEM and WB stages.
  logic [ADDR_WIDTH-1:0] mem_dest, wb_dest;
  logic                  mem_wr, mem_rd, mem_st, wb_wr;

  logic freeze, load_use;

  // Freeze depends only on the MEM shadow, so it is independent of the state
  // register; the FSM just tracks whether a wait is in progress. Reset masks
  // everything so outputs are quiet while reset is held.
  always_comb begin
    freeze   = 1'b0;
    load_use = 1'b0;
    if (!reset_i) begin
      freeze   = (mem_rd | mem_st) & ~mem_ready_i;
      load_use = ~freeze & ex_mem_read_i & ex_reg_write_i & (ex_dest_addr_i != PC_REG) &
                 (((ex_dest_addr_i == id_src1_addr_i) & id_src1_valid_i) |
                  ((ex_dest_addr_i == id_src2_addr_i) & id_src2_valid_i));
    end
  end

  assign freeze_o      = freeze;
  assign stall_o       = freeze | load_use;
  assign id_ex_flush_o = load_use;

  // MEM beats WB; a load sitting in MEM has no data yet, so it never forwards.
  always_comb begin
    fwd_sel_1_o = 2'b00;
    fwd_sel_2_o = 2'b00;
    if (!reset_i) begin
      if (ex_src1_addr_i != PC_REG) begin
        if (mem_wr && !mem_rd && mem_dest == ex_src1_addr_i) fwd_sel_1_o = 2'b01;
        else if (wb_wr && wb_dest == ex_src1_addr_i)         fwd_sel_1_o = 2'b10;
      end
      if (ex_src2_addr_i != PC_REG) begin
        if (mem_wr && !mem_rd && mem_dest == ex_src2_addr_i) fwd_sel_2_o = 2'b01;
        else if (wb_wr && wb_dest == ex_src2_addr_i)         fwd_sel_2_o = 2'b10;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= RUN;
      mem_dest <= '0;
      mem_wr   <= 1'b0;
      mem_rd   <= 1'b0;
      mem_st   <= 1'b0;
      wb_dest  <= '0;
      wb_wr    <= 1'b0;
    end else begin
      case (state)
        RUN:      if ((mem_rd | mem_st) && !mem_ready_i) state <= MEM_WAIT;
        MEM_WAIT: if (mem_ready_i) state <= RUN;
        default:  state <= RUN;
      endcase
      if (!freeze) begin
        mem_dest <= ex_dest_addr_i;
        mem_wr   <= ex_reg_write_i;
        mem_rd   <= ex_mem_read_i;
        mem_st   <= ex_mem_write_i;
        wb_dest  <= mem_dest;
        wb_wr    <= mem_wr;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      load_use_count_o <= '0;
      mem_wait_count_o <= '0;
    end else begin
      if (load_use && load_use_count_o != '1) load_use_count_o <= load_use_count_o + 1'b1;
      if (freeze && mem_wait_count_o != '1)   mem_wait_count_o <= mem_wait_count_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_execute_hazard_unit.sv
module tb_execute_hazard_unit;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [3:0] id_src1_addr_i, id_src2_addr_i;
  logic       id_src1_valid_i, id_src2_valid_i;
  logic [3:0] ex_src1_addr_i, ex_src2_addr_i, ex_dest_addr_i;
  logic       ex_reg_write_i, ex_mem_read_i, ex_mem_write_i;
  logic       mem_ready_i;
  logic [1:0] fwd_sel_1_o, fwd_sel_2_o;
  logic       stall_o, id_ex_flush_o, freeze_o;
`ifdef HAZARD_STATS_EN
  logic [15:0] load_use_count_o, mem_wait_count_o;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk_i = ~clk_i;

  execute_hazard_unit dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .id_src1_addr_i  (id_src1_addr_i),
    .id_src1_valid_i (id_src1_valid_i),
    .id_src2_addr_i  (id_src2_addr_i),
    .id_src2_valid_i (id_src2_valid_i),
    .ex_src1_addr_i  (ex_src1_addr_i),
    .ex_src2_addr_i  (ex_src2_addr_i),
    .ex_dest_addr_i  (ex_dest_addr_i),
    .ex_reg_write_i  (ex_reg_write_i),
    .ex_mem_read_i   (ex_mem_read_i),
    .ex_mem_write_i  (ex_mem_write_i),
    .mem_ready_i     (mem_ready_i),
    .fwd_sel_1_o     (fwd_sel_1_o),
    .fwd_sel_2_o     (fwd_sel_2_o),
    .stall_o         (stall_o),
    .id_ex_flush_o   (id_ex_flush_o),
    .freeze_o        (freeze_o)
`ifdef HAZARD_STATS_EN
    ,
    .load_use_count_o(load_use_count_o),
    .mem_wait_count_o(mem_wait_count_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive the ID/EX register contents.
  task automatic set_ex(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                        input logic wr, input logic rd, input logic st);
    ex_src1_addr_i = s1;
    ex_src2_addr_i = s2;
    ex_dest_addr_i = d;
    ex_reg_write_i = wr;
    ex_mem_read_i  = rd;
    ex_mem_write_i = st;
  endtask

  task automatic set_id(input logic [3:0] a1, input logic v1, input logic [3:0] a2, input logic v2);
    id_src1_addr_i  = a1;
    id_src1_valid_i = v1;
    id_src2_addr_i  = a2;
    id_src2_valid_i = v2;
  endtask

  // Advance one edge; inputs are changed and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Two idle edges flush MEM and WB shadows to non-writers.
  task automatic idle2();
    set_ex(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    set_id(4'd0, 1'b0, 4'd0, 1'b0);
    mem_ready_i = 1'b1;
    step();
    step();
  endtask

  initial begin
    reset_i = 1'b1;
    mem_ready_i = 1'b1;
    set_ex(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    set_id(4'd0, 1'b0, 4'd0, 1'b0);
    settle();
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_freeze", 32'(freeze_o), 32'd0);
    step();
    reset_i = 1'b0;
    settle();
    chk("post_rst_fwd1", 32'(fwd_sel_1_o), 32'd0);
    chk("post_rst_fwd2", 32'(fwd_sel_2_o), 32'd0);
    chk("post_rst_flush", 32'(id_ex_flush_o), 32'd0);

    // ALU writes r3, consumer follows: MEM forward then WB forward.
    set_ex(4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
    step();
    set_ex(4'd3, 4'd5, 4'd4, 1'b0, 1'b0, 1'b0);
    settle();
    chk("alu_fwd1_mem", 32'(fwd_sel_1_o), 32'd1);
    chk("alu_fwd2_none", 32'(fwd_sel_2_o), 32'd0);
    step();
    settle();
    chk("alu_fwd1_wb", 32'(fwd_sel_1_o), 32'd2);

    // Same register in MEM and WB: MEM wins.
    set_ex(4'd0, 4'd0, 4'd6, 1'b1, 1'b0, 1'b0);
    step();
    step();
    set_ex(4'd6, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("prio_fwd1", 32'(fwd_sel_1_o), 32'd1);
    chk("prio_fwd2", 32'(fwd_sel_2_o), 32'd1);

    // Load-use on r2 via src2.
    idle2();
    set_ex(4'd0, 4'd0, 4'd2, 1'b1, 1'b1, 1'b0);
    set_id(4'd9, 1'b0, 4'd2, 1'b1);
    settle();
    chk("lu_stall", 32'(stall_o), 32'd1);
    chk("lu_flush", 32'(id_ex_flush_o), 32'd1);
    chk("lu_freeze", 32'(freeze_o), 32'd0);
    step();
    set_ex(4'd0, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0);   // bubble in EX
    settle();
    chk("lu_bubble_stall", 32'(stall_o), 32'd0);
    chk("lu_bubble_flush", 32'(id_ex_flush_o), 32'd0);
    chk("lu_load_in_mem_nofwd", 32'(fwd_sel_2_o), 32'd0);
    step();
    set_ex(4'd0, 4'd2, 4'd7, 1'b1, 1'b0, 1'b0);   // dependent op re-decoded
    set_id(4'd0, 1'b0, 4'd0, 1'b0);
    settle();
    chk("lu_fwd2_wb", 32'(fwd_sel_2_o), 32'd2);

    // Load r7 in MEM, memory not ready for 3 cycles.
    idle2();
`ifdef HAZARD_STATS_EN
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
`endif
    set_ex(4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 1'b0);
    step();
    set_ex(4'd7, 4'd0, 4'd8, 1'b1, 1'b0, 1'b0);
    mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("wait%0d_freeze", i), 32'(freeze_o), 32'd1);
      chk($sformatf("wait%0d_stall", i), 32'(stall_o), 32'd1);
      chk($sformatf("wait%0d_flush", i), 32'(id_ex_flush_o), 32'd0);
      chk($sformatf("wait%0d_fwd1", i), 32'(fwd_sel_1_o), 32'd0);
      step();
    end
    mem_ready_i = 1'b1;
    settle();
    chk("wait_release_freeze", 32'(freeze_o), 32'd0);
    chk("wait_release_stall", 32'(stall_o), 32'd0);
    step();
    set_ex(4'd7, 4'd8, 4'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("wait_after_fwd1_wb", 32'(fwd_sel_1_o), 32'd2);
    chk("wait_after_fwd2_mem", 32'(fwd_sel_2_o), 32'd1);
`ifdef HAZARD_STATS_EN
    chk("stat_mem_wait", 32'(mem_wait_count_o), 32'd3);
    chk("stat_load_use", 32'(load_use_count_o), 32'd0);
`endif

    // r15 is never forwarded nor a load-use source.
    idle2();
    set_ex(4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 1'b0);
    step();
    step();
    set_ex(4'd15, 4'd15, 4'd15, 1'b1, 1'b1, 1'b0);
    set_id(4'd15, 1'b1, 4'd15, 1'b1);
    settle();
    chk("pc_fwd1", 32'(fwd_sel_1_o), 32'd0);
    chk("pc_fwd2", 32'(fwd_sel_2_o), 32'd0);
    chk("pc_stall", 32'(stall_o), 32'd0);
    chk("pc_flush", 32'(id_ex_flush_o), 32'd0);

    // Load-use coincident with a store waiting in MEM.
    idle2();
    set_ex(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    step();
    set_ex(4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0);
    set_id(4'd4, 1'b1, 4'd0, 1'b0);
    mem_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk($sformatf("co%0d_freeze", i), 32'(freeze_o), 32'd1);
      chk($sformatf("co%0d_flush", i), 32'(id_ex_flush_o), 32'd0);
      step();
    end
    mem_ready_i = 1'b1;
    settle();
    chk("co_rel_stall", 32'(stall_o), 32'd1);
    chk("co_rel_flush", 32'(id_ex_flush_o), 32'd1);
    step();
    set_ex(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("co_bubble_stall", 32'(stall_o), 32'd0);
    chk("co_bubble_freeze", 32'(freeze_o), 32'd0);

    // Reset while waiting on memory.
    idle2();
    set_ex(4'd0, 4'd0, 4'd9, 1'b1, 1'b1, 1'b0);
    step();
    set_ex(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    mem_ready_i = 1'b0;
    settle();
    chk("rw_freeze", 32'(freeze_o), 32'd1);
    step();
    reset_i = 1'b1;
    settle();
    chk("rw_in_rst_freeze", 32'(freeze_o), 32'd0);
    step();
    reset_i = 1'b0;
    set_ex(4'd9, 4'd9, 4'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("rw_freeze_after", 32'(freeze_o), 32'd0);
    chk("rw_stall_after", 32'(stall_o), 32'd0);
    chk("rw_fwd1_after", 32'(fwd_sel_1_o), 32'd0);
    chk("rw_fwd2_after", 32'(fwd_sel_2_o), 32'd0);
    step();
    settle();
    chk("rw_still_run", 32'(freeze_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
